// File: rtl/ebox_pkg.sv
// rtl/ebox_pkg.sv - shared EBOX types: IR dispatch states and IR source encodings
package ebox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAITCACHE = 3'd1,
    ST_LOADIR    = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LOADDRAM  = 3'd4,
    ST_READY     = 3'd5
  } irDispState_t;

  localparam logic [1:0] IRSRC_NONE  = 2'b00;
  localparam logic [1:0] IRSRC_CACHE = 2'b01;
  localparam logic [1:0] IRSRC_AD    = 2'b10;
  localparam logic [1:0] IRSRC_DIAG  = 2'b11;

endpackage

// File: rtl/ir_dispatch_ctl.sv
// rtl/ir_dispatch_ctl.sv - IR/DRAM load sequencer for the EBOX instruction-dispatch path
module ir_dispatch_ctl
  import ebox_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int SETTLE  = 1
) (
  input  logic       eboxClk,
  input  logic       eboxReset,
  input  logic       fetchReq,
  input  logic       cacheValid,
  input  logic       adLoadReq,
  input  logic       diagLoadReq,
  input  logic       diagHold,
  input  logic       dispatchAck,
  output logic       loadIR,
  output logic       mbXfer,
  output logic       loadDRAM,
  output logic       dispatchValid,
  output logic       busy,
  output logic [1:0] irSource,
  output logic       fetchTimeout
);

  // Last count value of each wait; the compare leaves the state before the counter could wrap.
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] SETTLE_LAST = 3'((SETTLE > 0) ? (SETTLE - 1) : 0);

  irDispState_t state, state_nxt;
  logic [7:0]   wait_cnt, wait_cnt_nxt;
  logic [2:0]   settle_cnt, settle_cnt_nxt;
  logic [1:0]   src_nxt;
  logic         tmo_nxt;

  // State, counters, source and timeout pulse registers.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 8'd0;
      settle_cnt   <= 3'd0;
      irSource     <= IRSRC_NONE;
      fetchTimeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      settle_cnt   <= settle_cnt_nxt;
      irSource     <= src_nxt;
      fetchTimeout <= tmo_nxt;
    end
  end

  // Next-state logic; diagHold freezes everything, so a held state re-executes on release.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    settle_cnt_nxt = settle_cnt;
    src_nxt        = irSource;
    tmo_nxt        = 1'b0;
    if (!diagHold) begin
      case (state)
        ST_IDLE: begin
          if (diagLoadReq) begin
            state_nxt = ST_LOADIR;
            src_nxt   = IRSRC_DIAG;
          end else if (adLoadReq) begin
            state_nxt = ST_LOADIR;
            src_nxt   = IRSRC_AD;
          end else if (fetchReq && cacheValid) begin
            state_nxt = ST_LOADIR;
            src_nxt   = IRSRC_CACHE;
          end else if (fetchReq) begin
            state_nxt    = ST_WAITCACHE;
            wait_cnt_nxt = 8'd0;
          end
        end
        ST_WAITCACHE: begin
          if (diagLoadReq) begin
            state_nxt = ST_LOADIR;
            src_nxt   = IRSRC_DIAG;
          end else if (cacheValid) begin
            state_nxt = ST_LOADIR;
            src_nxt   = IRSRC_CACHE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_IDLE;
            src_nxt   = IRSRC_NONE;
            tmo_nxt   = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
        ST_LOADIR: begin
          settle_cnt_nxt = 3'd0;
          state_nxt      = (SETTLE == 0) ? ST_LOADDRAM : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt = ST_LOADDRAM;
          end else begin
            settle_cnt_nxt = settle_cnt + 3'd1;
          end
        end
        ST_LOADDRAM: begin
          state_nxt = ST_READY;
        end
        ST_READY: begin
          if (dispatchAck) begin
            state_nxt = ST_IDLE;
            src_nxt   = IRSRC_NONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          src_nxt   = IRSRC_NONE;
        end
      endcase
    end
  end

  // Moore output decode; strobes are suppressed while held, the AD select follows the latched source.
  always_comb begin
    loadIR        = (state == ST_LOADIR) && !diagHold;
    loadDRAM      = (state == ST_LOADDRAM) && !diagHold;
    dispatchValid = (state == ST_READY);
    busy          = (state != ST_IDLE);
    mbXfer        = irSource[1] &&
                    ((state == ST_LOADIR) || (state == ST_SETTLE) ||
                     (state == ST_LOADDRAM) || (state == ST_READY));
  end

endmodule

// File: tb/tb_ir_dispatch_ctl.sv
// tb/tb_ir_dispatch_ctl.sv - self-checking bench for ir_dispatch_ctl against a cycle-age reference model
module tb_ir_dispatch_ctl;

  localparam int TO_A = 15;
  localparam int ST_A = 1;
  localparam int TO_B = 4;
  localparam int ST_B = 0;

  logic eboxClk = 1'b0;
  logic eboxReset = 1'b1;
  logic fetchReq = 1'b0, cacheValid = 1'b0, adLoadReq = 1'b0, diagLoadReq = 1'b0;
  logic diagHold = 1'b0, dispatchAck = 1'b0;

  logic       a_loadIR, a_mbXfer, a_loadDRAM, a_dispatchValid, a_busy, a_fetchTimeout;
  logic [1:0] a_irSource;
  logic       b_loadIR, b_mbXfer, b_loadDRAM, b_dispatchValid, b_busy, b_fetchTimeout;
  logic [1:0] b_irSource;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 eboxClk = ~eboxClk;

  ir_dispatch_ctl #(.TIMEOUT(TO_A), .SETTLE(ST_A)) dut_a (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .fetchReq(fetchReq), .cacheValid(cacheValid),
    .adLoadReq(adLoadReq), .diagLoadReq(diagLoadReq), .diagHold(diagHold), .dispatchAck(dispatchAck),
    .loadIR(a_loadIR), .mbXfer(a_mbXfer), .loadDRAM(a_loadDRAM), .dispatchValid(a_dispatchValid),
    .busy(a_busy), .irSource(a_irSource), .fetchTimeout(a_fetchTimeout)
  );

  ir_dispatch_ctl #(.TIMEOUT(TO_B), .SETTLE(ST_B)) dut_b (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .fetchReq(fetchReq), .cacheValid(cacheValid),
    .adLoadReq(adLoadReq), .diagLoadReq(diagLoadReq), .diagHold(diagHold), .dispatchAck(dispatchAck),
    .loadIR(b_loadIR), .mbXfer(b_mbXfer), .loadDRAM(b_loadDRAM), .dispatchValid(b_dispatchValid),
    .busy(b_busy), .irSource(b_irSource), .fetchTimeout(b_fetchTimeout)
  );

  // Output bundle: {busy, loadIR, mbXfer, loadDRAM, dispatchValid, irSource[1:0], fetchTimeout}
  wire [7:0] out_a = {a_busy, a_loadIR, a_mbXfer, a_loadDRAM, a_dispatchValid, a_irSource, a_fetchTimeout};
  wire [7:0] out_b = {b_busy, b_loadIR, b_mbXfer, b_loadDRAM, b_dispatchValid, b_irSource, b_fetchTimeout};

  // Reference model: mode 0 idle, 1 waiting for cache, 2 load in flight.
  // age counts unheld cycles since the IR load cycle; wage counts unheld cache-wait cycles.
  typedef struct {
    int         mode;
    int         age;
    int         wage;
    logic [1:0] src;
    bit         tmo;
  } mdl_t;

  mdl_t m_a, m_b, n_a, n_b;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.age = 0; m.wage = 0; m.src = 2'b00; m.tmo = 1'b0;
    return m;
  endfunction

  function automatic logic [7:0] mdl_out(mdl_t m, int s);
    logic ld_ir, ld_dram, valid, mbx;
    ld_ir   = (m.mode == 2) && (m.age == 0) && !diagHold;
    ld_dram = (m.mode == 2) && (m.age == s + 1) && !diagHold;
    valid   = (m.mode == 2) && (m.age >= s + 2);
    mbx     = (m.mode == 2) && m.src[1];
    return {m.mode != 0, ld_ir, mbx, ld_dram, valid, m.src, m.tmo};
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int s, int t);
    mdl_t n;
    n = m;
    n.tmo = 1'b0;
    if (diagHold) return n;
    case (m.mode)
      0: begin
        if (diagLoadReq)                 begin n.mode = 2; n.age = 0; n.src = 2'b11; end
        else if (adLoadReq)              begin n.mode = 2; n.age = 0; n.src = 2'b10; end
        else if (fetchReq && cacheValid) begin n.mode = 2; n.age = 0; n.src = 2'b01; end
        else if (fetchReq)               begin n.mode = 1; n.wage = 0; end
      end
      1: begin
        if (diagLoadReq)            begin n.mode = 2; n.age = 0; n.src = 2'b11; end
        else if (cacheValid)        begin n.mode = 2; n.age = 0; n.src = 2'b01; end
        else if (m.wage + 1 == t)   begin n.mode = 0; n.src = 2'b00; n.tmo = 1'b1; end
        else                        n.wage = m.wage + 1;
      end
      default: begin
        if (m.age >= s + 2) begin
          if (dispatchAck) begin n.mode = 0; n.src = 2'b00; end
        end else begin
          n.age = m.age + 1;
        end
      end
    endcase
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b (busy,ldIR,mbX,ldDRAM,valid,src,tmo)", tag, $time, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge, hand back control just after it.
  task automatic tick();
    @(negedge eboxClk);
    check("dut_a", out_a, mdl_out(m_a, ST_A));
    check("dut_b", out_b, mdl_out(m_b, ST_B));
    n_a = mdl_step(m_a, ST_A, TO_A);
    n_b = mdl_step(m_b, ST_B, TO_B);
    @(posedge eboxClk);
    #1;
    m_a = n_a;
    m_b = n_b;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    fetchReq = 0; cacheValid = 0; adLoadReq = 0; diagLoadReq = 0; diagHold = 0; dispatchAck = 0;
  endtask

  task automatic ack_once();
    dispatchAck = 1; tick(); dispatchAck = 0;
  endtask

  initial begin
    m_a = mdl_reset();
    m_b = mdl_reset();
    repeat (2) @(posedge eboxClk);
    #1;
    check("reset_a", out_a, 8'h00);
    check("reset_b", out_b, 8'h00);
    eboxReset = 0;

    // Cache fetch with data already valid.
    fetchReq = 1; cacheValid = 1; tick(); clear_inputs();
    ticks(5); ack_once(); ticks(4);

    // Fetch with cache data five cycles later.
    fetchReq = 1; tick(); fetchReq = 0;
    ticks(4); cacheValid = 1; tick(); cacheValid = 0;
    ticks(5); ack_once(); ticks(3);

    // Fetch with no cache response: both timeouts expire.
    fetchReq = 1; tick(); fetchReq = 0;
    ticks(20);

    // All three requests together, then a diag abort of a cache wait.
    diagLoadReq = 1; adLoadReq = 1; fetchReq = 1; tick(); clear_inputs();
    ticks(5); ack_once(); ticks(2);
    fetchReq = 1; tick(); fetchReq = 0;
    ticks(2); diagLoadReq = 1; tick(); diagLoadReq = 0;
    ticks(5); ack_once(); ticks(2);

    // Hold across the IR load, then hold across READY with ack present.
    fetchReq = 1; cacheValid = 1; tick(); clear_inputs();
    diagHold = 1; ticks(3); diagHold = 0;
    ticks(5); ack_once(); ticks(2);
    fetchReq = 1; cacheValid = 1; tick(); clear_inputs();
    ticks(4);
    diagHold = 1; dispatchAck = 1; ticks(3); diagHold = 0; dispatchAck = 0;
    tick(); ack_once(); ticks(2);

    // Asynchronous reset mid-sequence cuts strobes immediately.
    fetchReq = 1; cacheValid = 1; tick(); clear_inputs();
    tick();
    #2 eboxReset = 1;
    #1;
    check("async_rst_a", out_a, 8'h00);
    check("async_rst_b", out_b, 8'h00);
    @(posedge eboxClk);
    #1 eboxReset = 0;
    m_a = mdl_reset();
    m_b = mdl_reset();
    fetchReq = 1; cacheValid = 1; tick(); clear_inputs();
    ticks(5); ack_once(); ticks(2);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      fetchReq    = ($urandom_range(0, 99) < 35);
      cacheValid  = ($urandom_range(0, 99) < 25);
      adLoadReq   = ($urandom_range(0, 99) < 10);
      diagLoadReq = ($urandom_range(0, 99) < 5);
      diagHold    = ($urandom_range(0, 99) < 10);
      dispatchAck = ($urandom_range(0, 99) < 40);
      tick();
    end
    clear_inputs();
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_dispatch_ctl.md
# ir_dispatch_ctl

Sequencer that owns the IR/DRAM load strobes for the EBOX instruction-dispatch path. It arbitrates among three IR load sources: diagnostic load, AD-sourced load (XCT-style) and cache instruction fetch. It then issues `loadIR`, waits a programmable settle interval for the DRAM address to stabilise, issues `loadDRAM`, and presents a dispatch-ready handshake to the CRAM sequencer. It sits between the microcode/cache control and the IR board, and drives that board's `loadIR`, `mbXfer` and `loadDRAM` inputs.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum WAITCACHE cycles before a fetch is abandoned; legal range 1..255.
- `SETTLE`, 1: cycles between the `loadIR` pulse and the `loadDRAM` pulse; legal range 0..7.

Ports:
- `eboxClk` in 1: EBOX clock; every register updates on its rising edge.
- `eboxReset` in 1: reset, asynchronous, active-high.
- `fetchReq` in 1: microcode requests an instruction fetch from cache; level, sampled only in IDLE.
- `cacheValid` in 1: cache read data is valid this cycle.
- `adLoadReq` in 1: load IR from EDP AD; sampled only in IDLE.
- `diagLoadReq` in 1: diagnostic IR load through AD; sampled in IDLE and WAITCACHE.
- `diagHold` in 1: freeze the sequencer.
- `dispatchAck` in 1: the CRAM sequencer has consumed the dispatch.
- `loadIR` out 1: IR latch strobe.
- `mbXfer` out 1: IR source select; 1 = AD, 0 = cache.
- `loadDRAM` out 1: DRAM address/data latch strobe.
- `dispatchValid` out 1: IR and DRAM outputs are stable.
- `busy` out 1: state is not IDLE.
- `irSource` out 2: source of the current load; 00 none, 01 cache, 10 AD, 11 diag.
- `fetchTimeout` out 1: one-cycle pulse when a fetch is abandoned.

## Operation
- The FSM has six states: IDLE, WAITCACHE, LOADIR, SETTLE, LOADDRAM, READY. It is Moore-style.
- All outputs decode from registered state. `fetchTimeout` and `irSource` are registered directly.
- IDLE behaviour. Request priority is diag > AD > fetch:
  - `diagLoadReq` → LOADIR, source 11.
  - `adLoadReq` → LOADIR, source 10.
  - `fetchReq` with `cacheValid` → LOADIR, source 01.
  - `fetchReq` without `cacheValid` → WAITCACHE, wait counter cleared to 0.
- WAITCACHE behaviour. Checks apply in this order:
  - `diagLoadReq` → LOADIR, source 11. The fetch is abandoned silently and no timeout is raised.
  - `cacheValid` → LOADIR, source 01.
  - Wait counter == TIMEOUT−1 → IDLE, `fetchTimeout`=1 for the next cycle, `irSource`←00.
  - Otherwise the wait counter increments.
- LOADIR: `loadIR`=1. `mbXfer` is 1 for sources 10 and 11, and 0 for source 01.
  - Next state is SETTLE, with the settle counter cleared, or LOADDRAM directly when SETTLE=0.
- SETTLE: the settle counter increments. After SETTLE cycles the FSM goes to LOADDRAM.
- LOADDRAM: `loadDRAM`=1, then the FSM goes to READY.
- READY: `dispatchValid`=1 until `dispatchAck` is sampled high. The FSM then goes to IDLE and `irSource`←00.
- `mbXfer` holds its LOADIR value from LOADIR through READY. It is 0 in IDLE and WAITCACHE.
- `diagHold`=1 has the following effects:
  - State, counters and `irSource` hold.
  - `loadIR` and `loadDRAM` are forced to 0.
  - `dispatchValid` keeps its state-decoded value.
  - Requests and `cacheValid` arriving during the hold are ignored.
  - Releasing the hold re-executes the held state, so a held LOADIR pulses once after release.
- Counter widths: the wait counter is 8 bits and the settle counter is 3 bits. Neither wraps, because the compare ends the state first.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0. Reset is also effective mid-sequence: an in-progress `loadIR`/`loadDRAM` pulse is cut off in the same cycle.
- Strobe widths: `loadIR` and `loadDRAM` are each exactly one cycle wide (absent `diagHold`).
- Latency with SETTLE=s, counting from the request sample edge at cycle 0:
  - `loadIR` in cycle 1.
  - `loadDRAM` in cycle 2+s.
  - `dispatchValid` from cycle 3+s.
- `dispatchAck` sampled with `dispatchValid` ends READY. `busy` falls in the following cycle.
- An ack received while not in READY is ignored.
- Back-to-back operation: a request held high during the READY/ack cycle is taken in the first IDLE cycle. The minimum period is therefore 4+s cycles.
- Timeout: with no `cacheValid`, WAITCACHE lasts TIMEOUT cycles. `cacheValid` on the last WAITCACHE cycle wins over the timeout.

## Structure
- Shared package `ebox_pkg` holds:
  - the state enum `irDispState_t`;
  - the source encodings `IRSRC_NONE`, `IRSRC_CACHE`, `IRSRC_AD`, `IRSRC_DIAG`.
- A single module. No sub-module is warranted; the counters stay inline.

## Test plan
- Reset, then `fetchReq`+`cacheValid` in cycle 0 with SETTLE=1 → `loadIR`@1 with `mbXfer`=0, `loadDRAM`@3, `dispatchValid`@4, `irSource`=01. `dispatchAck`@6 → IDLE@7.
- `fetchReq` with `cacheValid` arriving 5 cycles later, TIMEOUT=15 → WAITCACHE lasts 5 cycles, then LOADIR. No `fetchTimeout`.
- `fetchReq` and no cache response, TIMEOUT=4 → 4 WAITCACHE cycles, then `fetchTimeout` pulses for exactly one cycle and `irSource`=00.
- `diagLoadReq`, `adLoadReq` and `fetchReq` all raised together in IDLE → source 11 with `mbXfer`=1. Then `diagLoadReq` asserted during WAITCACHE → abort to LOADIR with source 11.
- `diagHold` asserted during LOADIR for 3 cycles → `loadIR` stays 0 throughout the hold and pulses once after release. Repeat in READY: `dispatchValid` stays 1 and ack is ignored during the hold.
- `eboxReset` asserted asynchronously mid-SETTLE → all outputs 0 immediately. After release, a new fetch completes normally with SETTLE=0: `loadDRAM` in the cycle after `loadIR`.
